// File: rtl/stack_op_ctrl.sv
// Operation controller in front of the shift-register operand stack.
// Turns REPLACE and SWAP into legal one-push or one-pop cycles and tracks occupancy.
module stack_op_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           op_data,
    output logic                       pop_valid,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_overflow,
    output logic                       err_underflow,
    input  logic                       err_clear,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic [WIDTH-1:0]           stk_insert,
    input  logic [WIDTH-1:0]           stk_top
);
    // state   | meaning
    // IDLE    | ready for a new op; single-cycle ops complete here
    // R_PUSH  | REPLACE second cycle: push the held operand
    // S_POP2  | SWAP: pop the second word into hold_b
    // S_PUSH1 | SWAP: push old top (hold_a)
    // S_PUSH2 | SWAP: push old second (hold_b), lands on top
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] R_PUSH  = 3'd1;
    localparam logic [2:0] S_POP2  = 3'd2;
    localparam logic [2:0] S_PUSH1 = 3'd3;
    localparam logic [2:0] S_PUSH2 = 3'd4;

    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_DUP     = 3'd3;
    localparam logic [2:0] OP_REPLACE = 3'd4;
    localparam logic [2:0] OP_SWAP    = 3'd5;

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
    logic             ovf_set, udf_set, push_raw, pop_raw;
    logic [WIDTH-1:0] insert;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hold_a_d    = hold_a_q;
        hold_b_d    = hold_b_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_set     = 1'b0;
        udf_set     = 1'b0;
        push_raw    = 1'b0;
        pop_raw     = 1'b0;
        insert      = '0;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_PUSH: begin
                            if (count_q < DEPTH_C) begin
                                push_raw = 1'b1;
                                insert   = op_data;
                                count_d  = count_q + ONE_C;
                            end else begin
                                ovf_set = 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (count_q != '0) begin
                                pop_raw     = 1'b1;
                                pop_valid_d = 1'b1;
                                pop_data_d  = stk_top;
                                count_d     = count_q - ONE_C;
                            end else begin
                                udf_set = 1'b1;
                            end
                        end
                        OP_DUP: begin
                            // empty stack is an operand failure even though space exists
                            if (count_q == '0) begin
                                udf_set = 1'b1;
                            end else if (count_q == DEPTH_C) begin
                                ovf_set = 1'b1;
                            end else begin
                                push_raw = 1'b1;
                                insert   = stk_top;
                                count_d  = count_q + ONE_C;
                            end
                        end
                        OP_REPLACE: begin
                            if (count_q != '0) begin
                                pop_raw  = 1'b1;
                                hold_a_d = op_data;
                                state_d  = R_PUSH;
                            end else begin
                                udf_set = 1'b1;
                            end
                        end
                        OP_SWAP: begin
                            if (count_q >= TWO_C) begin
                                pop_raw  = 1'b1;
                                hold_a_d = stk_top;
                                state_d  = S_POP2;
                            end else begin
                                udf_set = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            R_PUSH: begin
                push_raw = 1'b1;
                insert   = hold_a_q;
                state_d  = IDLE;
            end
            S_POP2: begin
                pop_raw  = 1'b1;
                hold_b_d = stk_top;
                state_d  = S_PUSH1;
            end
            S_PUSH1: begin
                push_raw = 1'b1;
                insert   = hold_a_q;
                state_d  = S_PUSH2;
            end
            S_PUSH2: begin
                push_raw = 1'b1;
                insert   = hold_b_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a new error in the same cycle as err_clear must survive
        err_ovf_d = (err_ovf_q & ~err_clear) | ovf_set;
        err_udf_d = (err_udf_q & ~err_clear) | udf_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_udf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            err_ovf_q   <= err_ovf_d;
            err_udf_q   <= err_udf_d;
        end
    end

    // stack strobes are gated so nothing reaches the stack while reset is held
    assign stk_push      = push_raw & reset_n;
    assign stk_pop       = pop_raw & reset_n;
    assign stk_insert    = insert;
    assign op_ready      = (state_q == IDLE);
    assign count         = count_q;
    assign pop_valid     = pop_valid_q;
    assign pop_data      = pop_data_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_udf_q;
endmodule

// File: tb/tb_stack_op_ctrl.sv
// Directed bench for stack_op_ctrl with a behavioural shift-register stack attached.
module tb_stack_op_ctrl;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             op_valid, op_ready, pop_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_data, pop_data, stk_insert, stk_top;
    logic [2:0]       count;
    logic             err_overflow, err_underflow, err_clear;
    logic             stk_push, stk_pop;
    logic [WIDTH-1:0] mem [DEPTH];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stack_op_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .op_data(op_data), .pop_valid(pop_valid), .pop_data(pop_data),
        .count(count), .err_overflow(err_overflow), .err_underflow(err_underflow),
        .err_clear(err_clear), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_insert(stk_insert), .stk_top(stk_top)
    );

    // stack contents survive reset, like the real shift register
    always @(posedge clk) begin
        if (stk_push) begin
            for (int i = DEPTH-1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= stk_insert;
        end else if (stk_pop) begin
            for (int i = 0; i < DEPTH-1; i++) mem[i] <= mem[i+1];
            mem[DEPTH-1] <= '0;
        end
    end
    assign stk_top = mem[0];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] d);
        op_valid = 1'b1;
        op       = o;
        op_data  = d;
    endtask

    initial begin
        logic [31:0] exp_pop [4];
        exp_pop[0] = 32'h44; exp_pop[1] = 32'h33; exp_pop[2] = 32'h22; exp_pop[3] = 32'h11;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        reset_n = 1'b0; op_valid = 1'b0; op = 3'd0; op_data = '0; err_clear = 1'b0;
        #12;
        check_val("rst_count", 32'(count), 0);
        check_val("rst_ready", 32'(op_ready), 1);
        check_val("rst_errs", {30'd0, err_overflow, err_underflow}, 0);
        check_val("rst_popv", 32'(pop_valid), 0);
        reset_n = 1'b1;
        step();

        // fill the stack back-to-back
        for (int i = 0; i < 4; i++) begin
            drive(3'd1, 32'h11 * (i + 1));
            @(negedge clk);
            check_val("push_ready", 32'(op_ready), 1);
            check_val("push_strobe", {30'd0, stk_push, stk_pop}, 2);
            check_val("push_insert", stk_insert, 32'h11 * (i + 1));
            step();
            check_val("push_count", 32'(count), i + 1);
        end
        check_val("full_top", stk_top, 32'h44);

        // overflow
        drive(3'd1, 32'h55);
        @(negedge clk);
        check_val("ovf_nopush", 32'(stk_push), 0);
        step();
        op_valid = 1'b0;
        check_val("ovf_err", 32'(err_overflow), 1);
        check_val("ovf_udf", 32'(err_underflow), 0);
        check_val("ovf_count", 32'(count), 4);
        check_val("ovf_top", stk_top, 32'h44);

        // drain, then underflow
        for (int i = 0; i < 4; i++) begin
            drive(3'd2, 32'h0);
            @(negedge clk);
            check_val("pop_strobe", {30'd0, stk_push, stk_pop}, 1);
            step();
            check_val("pop_valid", 32'(pop_valid), 1);
            check_val("pop_data", pop_data, exp_pop[i]);
            check_val("pop_count", 32'(count), 3 - i);
        end
        drive(3'd2, 32'h0);
        @(negedge clk);
        check_val("udf_nopop", 32'(stk_pop), 0);
        step();
        op_valid = 1'b0;
        check_val("udf_err", 32'(err_underflow), 1);
        check_val("udf_count", 32'(count), 0);
        check_val("udf_popv", 32'(pop_valid), 0);

        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check_val("clr_errs", {30'd0, err_overflow, err_underflow}, 0);

        // SWAP at count 2
        drive(3'd1, 32'hA); step();
        drive(3'd1, 32'hB); step();
        drive(3'd5, 32'h0); step();
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("swap_busy", 32'(op_ready), 0);
            check_val("swap_count", 32'(count), 2);
            check_val("swap_nopv", 32'(pop_valid), 0);
            step();
        end
        check_val("swap_ready", 32'(op_ready), 1);
        check_val("swap_top", stk_top, 32'hA);
        check_val("swap_second", mem[1], 32'hB);
        check_val("swap_count_end", 32'(count), 2);

        // SWAP at count 1
        drive(3'd2, 32'h0); step();
        check_val("pre_swap1_pop", pop_data, 32'hA);
        drive(3'd5, 32'h0);
        @(negedge clk);
        check_val("swap1_nostrobe", {30'd0, stk_push, stk_pop}, 0);
        step();
        op_valid = 1'b0;
        check_val("swap1_errs", {30'd0, err_overflow, err_underflow}, 1);
        check_val("swap1_count", 32'(count), 1);
        check_val("swap1_ready", 32'(op_ready), 1);

        // REPLACE and DUP starting from empty
        drive(3'd2, 32'h0); step();
        check_val("drain_count", 32'(count), 0);
        drive(3'd1, 32'h7); step();
        drive(3'd4, 32'h9);
        @(negedge clk);
        check_val("repl_pop", {30'd0, stk_push, stk_pop}, 1);
        step();
        op_valid = 1'b0;
        @(negedge clk);
        check_val("repl_push", {30'd0, stk_push, stk_pop}, 2);
        check_val("repl_insert", stk_insert, 32'h9);
        check_val("repl_count_mid", 32'(count), 1);
        step();
        check_val("repl_top", stk_top, 32'h9);
        check_val("repl_count", 32'(count), 1);
        drive(3'd3, 32'h0);
        @(negedge clk);
        check_val("dup_insert", stk_insert, 32'h9);
        step();
        op_valid = 1'b0;
        check_val("dup_count", 32'(count), 2);
        check_val("dup_top", stk_top, 32'h9);
        check_val("dup_second", mem[1], 32'h9);

        // reset during S_PUSH1 of a SWAP (underflow still sticky from earlier)
        drive(3'd5, 32'h0); step();
        op_valid = 1'b0;
        step();
        @(negedge clk);
        check_val("s_push1_push", {30'd0, stk_push, stk_pop}, 2);
        #1;
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_strobes", {30'd0, stk_push, stk_pop}, 0);
        check_val("rst_mid_ready", 32'(op_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_val("rst_mid_count", 32'(count), 0);
        check_val("rst_mid_errs", {30'd0, err_overflow, err_underflow}, 0);

        // err_clear together with a new overflow
        for (int i = 0; i < 4; i++) begin
            drive(3'd1, 32'h100 + i); step();
        end
        check_val("refill_count", 32'(count), 4);
        drive(3'd1, 32'h200);
        err_clear = 1'b1;
        step();
        op_valid = 1'b0;
        err_clear = 1'b0;
        check_val("clr_vs_ovf", 32'(err_overflow), 1);
        check_val("clr_vs_ovf_count", 32'(count), 4);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check_val("clr_final", 32'(err_overflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stack_op_ctrl.md
Name: stack_op_ctrl

Overview:
- Controller directly upstream of the shift-register operand stack (push/pop/insert in, top out).
- Accepts stack operations from the decode stage over a valid/ready handshake and tracks occupancy.
- Sequences multi-cycle ops (REPLACE, SWAP) into legal single push or single pop cycles.
- Returns popped values and raises sticky overflow/underflow errors.

Parameters:
- WIDTH, 32, data word width; must match the stack.
- DEPTH, 2, stack depth in words; must match the stack; DEPTH >= 2.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op_valid  in  1  operation request valid.
- op_ready  out  1  controller can accept an op this cycle.
- op  in  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 REPLACE, 5 SWAP, 6/7 NOP.
- op_data  in  WIDTH  operand for PUSH and REPLACE.
- pop_valid  out  1  one-cycle pulse: pop_data holds the value removed by POP.
- pop_data  out  WIDTH  popped value.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- err_overflow  out  1  sticky; op rejected for lack of space.
- err_underflow  out  1  sticky; op rejected for lack of operands.
- err_clear  in  1  synchronous clear of both sticky errors.
- stk_push  out  1  to stack push.
- stk_pop  out  1  to stack pop.
- stk_insert  out  WIDTH  to stack insert.
- stk_top  in  WIDTH  from stack top.

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, count=0, pop_valid=0, pop_data=0, errors=0, hold registers=0.
  - stk_push=stk_pop=0 while reset_n is low.
  - Stack contents are not cleared; count=0 defines the stack as empty.
- Handshake:
  - op_ready=1 only in state IDLE.
  - An op is accepted on a rising edge with op_valid & op_ready.
  - op/op_data must be stable only in the accept cycle.
- Stack drive:
  - stk_push/stk_pop are combinational from state and the accepted op.
  - They are never both 1 in the same cycle.
  - The stack updates on the same edge.
- Legality check at accept (on the current count):
  - PUSH needs count<DEPTH.
  - POP and REPLACE need count>=1.
  - DUP needs 1<=count<DEPTH.
  - SWAP needs count>=2.
  - Space failure: set err_overflow. Operand failure: set err_underflow. DUP with count=0 is underflow.
  - An illegal op is still consumed (1 cycle), with no stack action and no count change.
- PUSH: accept cycle stk_push=1, stk_insert=op_data; count+1. Latency 1.
- POP: accept cycle stk_pop=1; pop_data<=stk_top, pop_valid=1 the next cycle only; count-1.
- DUP: accept cycle stk_push=1, stk_insert=stk_top; count+1.
- REPLACE (2 cycles, net count 0):
  - Accept cycle: stk_pop=1, hold_a<=op_data, state->R_PUSH.
  - R_PUSH: stk_push=1, stk_insert=hold_a, state->IDLE.
- SWAP (4 cycles, net count 0):
  - Accept cycle: stk_pop=1, hold_a<=stk_top, ->S_POP2.
  - S_POP2: stk_pop=1, hold_b<=stk_top, ->S_PUSH1.
  - S_PUSH1: stk_push=1, stk_insert=hold_a, ->S_PUSH2.
  - S_PUSH2: stk_push=1, stk_insert=hold_b, ->IDLE.
  - Result: old top and second exchanged.
- NOP and reserved opcodes: accepted, no effect.
- count:
  - Changes only for PUSH/POP/DUP at accept.
  - Mid-sequence values are internal; the output count holds the pre-op value until the sequence completes.
  - count never wraps: guaranteed by the legality checks.
- Errors:
  - Sticky until err_clear.
  - If err_clear and a new error occur in the same cycle, the error wins (stays set).
- Reset mid-sequence: aborts immediately to IDLE with count=0; the partial stack state is discarded by definition.

Test Plan (WIDTH=32, DEPTH=4):
- PUSH 0x11, 0x22, 0x33, 0x44 back-to-back -> count 1..4 each cycle, stk_top=0x44, op_ready constant 1.
- At count=4, PUSH 0x55 -> err_overflow=1, count stays 4, stk_push never asserted, top still 0x44.
- POP x4 then POP again -> pop_data 0x44,0x33,0x22,0x11 with pop_valid pulses one cycle after each accept; fifth POP sets err_underflow, count=0, no pop_valid.
- Push 0xA, 0xB; SWAP -> op_ready low 3 cycles, top=0xA then second=0xB, count=2 throughout; SWAP at count=1 -> err_underflow only.
- Push 0x7; REPLACE 0x9 -> pop then push on consecutive cycles, top=0x9, count=1; DUP -> count=2, top=second=0x9.
- Assert reset_n low during S_PUSH1 of a SWAP -> stk_push/stk_pop drop immediately; after release count=0, op_ready=1, errors 0; err_clear with simultaneous new overflow leaves err_overflow=1.
